axi_err_slave: RTL
==================

AXI_ERR_SLAVE -- requirements
Module: axi_err_slave

Interface
REQ-001 SHALL have parameter ID_W, default 8, meaning AXI ID width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning R data width.
REQ-003 SHALL have parameter LEN_W, default 4, meaning burst length field width; a burst is LEN+1 beats.
REQ-004 SHALL have parameter RESP, default 2'b11 (DECERR), meaning the response code driven on RRESP and BRESP.
REQ-005 SHALL have port ACLK  input  1  clock; all logic rising-edge.
REQ-006 SHALL have port ARESETn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ARID  input  ID_W  read ID.
REQ-008 SHALL have port ARLEN  input  LEN_W  read burst length.
REQ-009 SHALL have port ARVALID/ARREADY  input/output  1/1  AR handshake.
REQ-010 SHALL have port RID  output  ID_W  captured ARID.
REQ-011 SHALL have port RDATA  output  DATA_W  constant all-zeros.
REQ-012 SHALL have port RRESP  output  2  constant RESP.
REQ-013 SHALL have port RLAST  output  1  final beat flag.
REQ-014 SHALL have port RVALID/RREADY  output/input  1/1  R handshake.
REQ-015 SHALL have port AWID  input  ID_W  write ID.
REQ-016 SHALL have port AWVALID/AWREADY  input/output  1/1  AW handshake.
REQ-017 SHALL have port WLAST  input  1  final write beat; W data and strobes are not ports and are discarded.
REQ-018 SHALL have port WVALID/WREADY  input/output  1/1  W handshake.
REQ-019 SHALL have port BID  output  ID_W  captured AWID.
REQ-020 SHALL have port BRESP  output  2  constant RESP.
REQ-021 SHALL have port BVALID/BREADY  output/input  1/1  B handshake.
REQ-022 SHALL have port ERR_CNT  output  16  completed-transaction count; present only with AXI_ERR_CNT_EN.

Function
REQ-023 SHALL run independent read FSM (R_IDLE, R_DATA) and write FSM (W_IDLE, W_DATA, W_RESP) concurrently, each with one outstanding transaction.
REQ-024 SHALL drive ARREADY=1 only in R_IDLE; on ARVALID&&ARREADY SHALL capture ARID into RID and ARLEN into a beat counter, then enter R_DATA.
REQ-025 SHALL assert RVALID in the cycle after the AR handshake and hold it, and RID/RLAST, stable until RREADY.
REQ-026 SHALL decrement the beat counter per R handshake; RLAST=1 exactly when counter==0; with RREADY held high, beats SHALL issue every cycle.
REQ-027 SHALL, on the RLAST handshake, deassert RVALID and RLAST, return to R_IDLE, and set ARREADY=1 in the next cycle.
REQ-028 SHALL drive AWREADY=1 only in W_IDLE; on the AW handshake SHALL capture AWID into BID and enter W_DATA with WREADY=1 in the next cycle.
REQ-029 SHALL hold WREADY=0 outside W_DATA, so W beats arriving before AW stall.
REQ-030 SHALL accept W beats until WVALID&&WREADY&&WLAST, then enter W_RESP with WREADY=0 and BVALID=1 in the next cycle; beat count is not checked against AWLEN.
REQ-031 SHALL hold BVALID until BREADY, then return to W_IDLE with AWREADY=1 in the next cycle.
REQ-032 SHALL never deassert RVALID or BVALID without a completed handshake; ARLEN=2^LEN_W-1 SHALL yield 2^LEN_W beats with no counter wrap.

Reset
REQ-033 SHALL, while ARESETn=0, force ARREADY=1, AWREADY=1, RVALID=0, RLAST=0, WREADY=0, BVALID=0, RID=0, BID=0, counters=0, ERR_CNT=0, and both FSMs idle.
REQ-034 SHALL, on reset mid-burst, discard all in-flight transactions with no further R or B beats.

Configuration
REQ-035 SHALL, with AXI_ERR_CNT_EN defined, increment ERR_CNT by 1 per RLAST handshake and per B handshake, by 2 when both occur in the same cycle, saturating at 16'hFFFF; without the macro, the ERR_CNT port and its logic SHALL not exist.

Verification
REQ-036 SHALL cover: ARID=5, ARLEN=3, RREADY=1 -> 4 consecutive beats, RID=5, RRESP=2'b11, RDATA=0, RLAST on beat 4 only, ARREADY=1 next cycle.
REQ-037 SHALL cover: ARLEN=0, RREADY low 3 cycles -> RVALID and RLAST held stable, single beat when RREADY rises.
REQ-038 SHALL cover: WVALID with WLAST before AWVALID -> WREADY=0; AWID=9 then accepted -> W accepted, BVALID with BID=9, BRESP=2'b11, held until BREADY.
REQ-039 SHALL cover: concurrent read ARLEN=1 and write of 2 beats finishing in the same cycle -> both complete independently, ERR_CNT +2 (macro on).
REQ-040 SHALL cover: ARESETn low during beat 2 of ARLEN=7 -> RVALID=0, ARREADY=1 immediately, no further beats after release.

Source files
------------

// File: rtl/axi_err_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : axi_err_slave
// Brief   : AXI error slave; completes every burst with RESP. Define
//           AXI_ERR_CNT_EN to add the ERR_CNT completed-transaction counter.
// Revision: 1.0 - initial release
// ============================================================================
module axi_err_slave #(
    parameter int          ID_W   = 8,
    parameter int          DATA_W = 32,
    parameter int          LEN_W  = 4,
    parameter logic [1:0]  RESP   = 2'b11
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ID_W-1:0]   ARID,
    input  logic [LEN_W-1:0]  ARLEN,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    input  logic [ID_W-1:0]   AWID,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [ID_W-1:0]   BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY
`ifdef AXI_ERR_CNT_EN
    ,
    output logic [15:0]       ERR_CNT
`endif
);

    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;

    r_state_t          r_state_q, r_state_d;
    w_state_t          w_state_q, w_state_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q  <= R_IDLE;
            w_state_q  <= W_IDLE;
            rid_q      <= '0;
            bid_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            r_state_q  <= r_state_d;
            w_state_q  <= w_state_d;
            rid_q      <= rid_d;
            bid_q      <= bid_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Counter holds remaining beats minus one, so a full-width ARLEN never wraps
    always_comb begin
        r_state_d  = r_state_q;
        rid_d      = rid_q;
        beat_cnt_d = beat_cnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID) begin
                    rid_d      = ARID;
                    beat_cnt_d = ARLEN;
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    if (beat_cnt_q == '0) begin
                        r_state_d = R_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        case (w_state_q)
            W_IDLE: begin
                if (AWVALID) begin
                    bid_d     = AWID;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID && WLAST) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign ARREADY = (r_state_q == R_IDLE);
    assign RVALID  = (r_state_q == R_DATA);
    assign RLAST   = RVALID && (beat_cnt_q == '0);
    assign RID     = rid_q;
    assign RDATA   = '0;
    assign RRESP   = RESP;

    assign AWREADY = (w_state_q == W_IDLE);
    assign WREADY  = (w_state_q == W_DATA);
    assign BVALID  = (w_state_q == W_RESP);
    assign BID     = bid_q;
    assign BRESP   = RESP;

`ifdef AXI_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [1:0]  err_inc;
    logic [16:0] err_sum;

    // Read and write completions can land in the same cycle: add both, then saturate
    always_comb begin
        err_inc   = {1'b0, RVALID && RREADY && RLAST} + {1'b0, BVALID && BREADY};
        err_sum   = {1'b0, err_cnt_q} + {15'b0, err_inc};
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ERR_CNT = err_cnt_q;
`endif

endmodule
`default_nettype wire
